// File: rtl/cordic_trig_seq.sv
// Sequential CORDIC sine/cosine unit.
// Takes an IEEE-754 single angle in radians (|angle| <= 1.0). Converts it to
// signed fixed point, runs ITER rotation-mode micro-rotations, and packs the
// selected coordinate back to float32 with mantissa truncation.
// Out-of-range, Inf and NaN inputs still take the full latency and return a quiet NaN.
module cordic_trig_seq #(
  parameter int unsigned FRAC = 22,
  parameter int unsigned ITER = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clk_en,
  input  logic        start,
  input  logic        n,
  input  logic [31:0] dataa,
  output logic [31:0] result,
  output logic        done
);

  localparam int unsigned W  = FRAC + 3;
  localparam int unsigned IW = $clog2(ITER);

  // atan(2^-idx) scaled by 2^60, from an integer Taylor series (pi/4 for idx 0)
  function automatic logic [63:0] atan_q60(input int unsigned idx);
    logic [63:0]  acc;
    logic [63:0]  term;
    int unsigned  e;
    acc = '0;
    if (idx == 0) return 64'h0C90_FDAA_2216_8C23;
    for (int unsigned k = 0; k < 61; k++) begin
      e = idx * (2 * k + 1);
      if (e <= 60) begin
        term = (64'd1 << (60 - e)) / 64'(2 * k + 1);
        if ((k % 2) == 1) acc = acc - term;
        else              acc = acc + term;
      end
    end
    return acc;
  endfunction

  // Round the high-precision value to FRAC fractional bits
  function automatic logic [W-1:0] atan_fix(input int unsigned idx);
    logic [63:0] r;
    r = (atan_q60(idx) + (64'd1 << (59 - FRAC))) >> (60 - FRAC);
    return r[W-1:0];
  endfunction

  // Reciprocal of the CORDIC gain, preloaded into x
  localparam logic [W-1:0] X_INIT =
    W'(((64'd6072529350 << FRAC) + 64'd5000000000) / 64'd10000000000);

  typedef enum logic [1:0] {IDLE, CONV, ROT, PACK} state_t;

  state_t                state;
  logic [31:0]           ang;
  logic                  sel_sin;
  logic                  oor;
  logic signed [W-1:0]   x;
  logic signed [W-1:0]   y;
  logic signed [W-1:0]   z;
  logic [IW-1:0]         i;

  logic [W-1:0]          atan_lut [ITER];

  for (genvar g = 0; g < ITER; g++) begin : g_atan
    localparam logic [W-1:0] ATAN_G = atan_fix(g);
    assign atan_lut[g] = ATAN_G;
  end

  // Float-to-fixed conversion of the captured angle
  logic [7:0]            a_exp;
  logic [7:0]            sh;
  logic [FRAC+23:0]      sig_ext;
  logic [W-1:0]          mag;
  logic signed [W-1:0]   conv_z;
  logic                  conv_oor;

  assign a_exp = ang[30:23];

  // Decode the exponent and right-shift the significand into Q(FRAC) fixed point
  always_comb begin
    conv_oor = 1'b0;
    conv_z   = '0;
    sh       = '0;
    sig_ext  = '0;
    mag      = '0;
    if (a_exp == 8'hFF) begin
      conv_oor = 1'b1;
    end else if (a_exp > 8'd127 || (a_exp == 8'd127 && ang[22:0] != 23'd0)) begin
      conv_oor = 1'b1;
    end else if (a_exp != 8'd0 && a_exp >= 8'(127 - FRAC)) begin
      sh      = 8'd150 - a_exp;
      sig_ext = {1'b1, ang[22:0], {FRAC{1'b0}}};
      mag     = W'(sig_ext >> sh);
      conv_z  = ang[31] ? -mag : mag;
    end
  end

  // Fixed-to-float packing of the selected coordinate
  logic signed [W-1:0]   pv;
  logic [W-1:0]          pmag;
  logic [W-1:0]          pshift;
  int unsigned           lead;
  logic [22:0]           mant;
  logic [7:0]            pexp;
  logic [31:0]           pack_val;

  // Leading-one normalisation; the shift pushes the hidden bit out the top
  always_comb begin
    pv     = sel_sin ? y : x;
    pmag   = pv[W-1] ? -pv : pv;
    lead   = 0;
    for (int unsigned b = 0; b < W; b++) begin
      if (pmag[b]) lead = b;
    end
    pshift = pmag << (W - lead);
    mant   = 23'({pshift, 23'd0} >> W);
    pexp   = 8'(127 + lead - FRAC);
    if (oor)              pack_val = 32'h7FC0_0000;
    else if (pmag == '0)  pack_val = 32'h0000_0000;
    else                  pack_val = {pv[W-1], pexp, mant};
  end

  // Control FSM and datapath; nothing moves while clk_en is low
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      ang     <= '0;
      sel_sin <= 1'b0;
      oor     <= 1'b0;
      x       <= '0;
      y       <= '0;
      z       <= '0;
      i       <= '0;
      result  <= '0;
      done    <= 1'b0;
    end else if (clk_en) begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            ang     <= dataa;
            sel_sin <= n;
            state   <= CONV;
          end
        end
        CONV: begin
          x     <= X_INIT;
          y     <= '0;
          z     <= conv_z;
          oor   <= conv_oor;
          i     <= '0;
          state <= ROT;
        end
        ROT: begin
          if (z[W-1]) begin
            x <= x + (y >>> i);
            y <= y - (x >>> i);
            z <= z + atan_lut[i];
          end else begin
            x <= x - (y >>> i);
            y <= y + (x >>> i);
            z <= z - atan_lut[i];
          end
          i <= i + 1'b1;
          if (i == IW'(ITER - 1)) state <= PACK;
        end
        PACK: begin
          // PACK spans two cycles so done is high while still in PACK,
          // which keeps a start coinciding with done from being accepted
          if (!done) begin
            result <= pack_val;
            done   <= 1'b1;
          end else begin
            done  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_trig_seq.sv
// Directed bench for cordic_trig_seq: reset, cos/sin accuracy, tiny angles,
// out-of-range inputs, clock-enable stalls, start during done, mid-run reset.
module tb_cordic_trig_seq;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        clk_en = 1'b1;
  logic        start = 1'b0;
  logic        n = 1'b0;
  logic [31:0] dataa = '0;
  logic [31:0] result;
  logic        done;

  int checks = 0;
  int failures = 0;

  localparam real TOL  = 6.103515625e-5;   // 2^-14
  localparam real COS1 = 0.5403023058681398;
  localparam real SINM1 = -0.8414709848078965;
  localparam real COSH = 0.8775825618903728;

  logic [31:0] r_ref;

  always #5 clk = ~clk;

  cordic_trig_seq #(.FRAC(22), .ITER(16)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .clk_en  (clk_en),
    .start   (start),
    .n       (n),
    .dataa   (dataa),
    .result  (result),
    .done    (done)
  );

  function automatic real f2r(input logic [31:0] b);
    real v;
    int  e;
    if (b[30:23] == 8'd0) return 0.0;
    v = 1.0 + real'(b[22:0]) / 8388608.0;
    e = int'(b[30:23]) - 127;
    if (e > 0) repeat (e) v = v * 2.0;
    else       repeat (-e) v = v / 2.0;
    return b[31] ? -v : v;
  endfunction

  function automatic real absr(input real a);
    return (a < 0.0) ? -a : a;
  endfunction

  // Called at a negedge; returns at a negedge one cycle after done was seen.
  task automatic run_op(input logic [31:0] a, input logic nb, input int gap_at,
                        input int gap_len, input int pulse_at,
                        output logic [31:0] res, output int lat,
                        output logic dn_next, output logic [31:0] res_next);
    dataa = a; n = nb; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; dataa = 32'hDEAD_BEEF; n = ~nb;
    lat = 0;
    while (lat < 200) begin
      @(posedge clk); lat++;
      @(negedge clk);
      if (lat == gap_at) clk_en = 1'b0;
      if (lat == gap_at + gap_len) clk_en = 1'b1;
      if (lat == pulse_at) begin start = 1'b1; dataa = 32'h3F00_0000; end
      if (lat == pulse_at + 1) start = 1'b0;
      if (done) break;
    end
    res = result;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    dn_next = done;
    res_next = result;
  endtask

  task automatic test_reset();
    logic [31:0] r, rn; int lat; logic dn;
    @(negedge clk); @(negedge clk);
    checks++; if (result !== 32'h0) begin failures++; $display("FAIL reset_result got=%h exp=00000000", result); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    reset_n = 1'b1;
    run_op(32'h3F80_0000, 1'b0, -1, 0, -1, r, lat, dn, rn);
    checks++; if (lat != 18) begin failures++; $display("FAIL first_start_latency got=%0d exp=18", lat); end
    checks++; if (absr(f2r(r) - COS1) > TOL) begin failures++; $display("FAIL first_start_cos1 got=%h exp~3F0A5140", r); end
  endtask

  task automatic test_cos_one();
    logic [31:0] r, rn; int lat; logic dn;
    run_op(32'h3F80_0000, 1'b0, -1, 0, -1, r, lat, dn, rn);
    r_ref = r;
    checks++; if (lat != 18) begin failures++; $display("FAIL cos1_latency got=%0d exp=18", lat); end
    checks++; if (absr(f2r(r) - COS1) > TOL) begin failures++; $display("FAIL cos1_value got=%h exp~3F0A5140", r); end
    checks++; if (r[31] !== 1'b0) begin failures++; $display("FAIL cos1_sign got=%b exp=0", r[31]); end
    checks++; if (dn !== 1'b0) begin failures++; $display("FAIL cos1_done_width got=%b exp=0", dn); end
    checks++; if (rn !== r) begin failures++; $display("FAIL cos1_result_hold got=%h exp=%h", rn, r); end
  endtask

  task automatic test_sin_cos();
    logic [31:0] r, rn; int lat; logic dn;
    run_op(32'hBF80_0000, 1'b1, -1, 0, -1, r, lat, dn, rn);
    checks++; if (lat != 18) begin failures++; $display("FAIL sinm1_latency got=%0d exp=18", lat); end
    checks++; if (absr(f2r(r) - SINM1) > TOL) begin failures++; $display("FAIL sinm1_value got=%h exp~BF576AA4", r); end
    checks++; if (r[31] !== 1'b1) begin failures++; $display("FAIL sinm1_sign got=%b exp=1", r[31]); end
    run_op(32'h3F00_0000, 1'b0, -1, 0, -1, r, lat, dn, rn);
    checks++; if (absr(f2r(r) - COSH) > TOL) begin failures++; $display("FAIL cos_half_value got=%h exp~3F60A940", r); end
  endtask

  task automatic test_small();
    logic [31:0] ins [4] = '{32'h0000_0000, 32'h3380_0000, 32'h0000_0000, 32'h3380_0000};
    logic        sel [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    real         exv [4] = '{1.0, 1.0, 0.0, 0.0};
    logic [31:0] r, rn; int lat; logic dn;
    for (int k = 0; k < 4; k++) begin
      run_op(ins[k], sel[k], -1, 0, -1, r, lat, dn, rn);
      checks++;
      if (absr(f2r(r) - exv[k]) > TOL) begin
        failures++; $display("FAIL small_angle_%0d got=%h exp~%f", k, r, exv[k]);
      end
    end
  endtask

  task automatic test_out_of_range();
    logic [31:0] ins [5] = '{32'h4000_0000, 32'h7FC0_0000, 32'h7F80_0000, 32'h3F80_0001, 32'hBF80_0001};
    logic [31:0] r, rn; int lat; logic dn;
    for (int k = 0; k < 5; k++) begin
      run_op(ins[k], k[0], -1, 0, -1, r, lat, dn, rn);
      checks++;
      if (r !== 32'h7FC0_0000) begin failures++; $display("FAIL oor_value_%0d got=%h exp=7FC00000", k, r); end
      checks++;
      if (lat != 18) begin failures++; $display("FAIL oor_latency_%0d got=%0d exp=18", k, lat); end
    end
  endtask

  task automatic test_clk_en();
    logic [31:0] r, rn; int lat; logic dn;
    run_op(32'h3F80_0000, 1'b0, 5, 5, 12, r, lat, dn, rn);
    checks++; if (lat != 23) begin failures++; $display("FAIL stall_latency got=%0d exp=23", lat); end
    checks++; if (r !== r_ref) begin failures++; $display("FAIL stall_result got=%h exp=%h", r, r_ref); end
    checks++; if (absr(f2r(r) - COS1) > TOL) begin failures++; $display("FAIL stall_value got=%h exp~3F0A5140", r); end
    checks++; if (dn !== 1'b0) begin failures++; $display("FAIL stall_extra_done got=%b exp=0", dn); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r, rn; int lat; logic dn; int seen;
    run_op(32'h3F80_0000, 1'b0, -1, 0, 18, r, lat, dn, rn);
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (done) seen++;
    end
    checks++; if (seen != 0) begin failures++; $display("FAIL start_during_done got=%0d done_cycles exp=0", seen); end
    run_op(32'h3F80_0000, 1'b0, -1, 0, -1, r, lat, dn, rn);
    checks++; if (lat != 18) begin failures++; $display("FAIL after_b2b_latency got=%0d exp=18", lat); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] r, rn; int lat; logic dn; int seen;
    dataa = 32'h3F80_0000; n = 1'b0; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL midreset_done got=%b exp=0", done); end
    checks++; if (result !== 32'h0) begin failures++; $display("FAIL midreset_result got=%h exp=00000000", result); end
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    seen = 0;
    repeat (25) begin
      @(negedge clk);
      if (done) seen++;
    end
    checks++; if (seen != 0) begin failures++; $display("FAIL midreset_no_done got=%0d exp=0", seen); end
    run_op(32'h3F80_0000, 1'b0, -1, 0, -1, r, lat, dn, rn);
    checks++; if (lat != 18) begin failures++; $display("FAIL midreset_restart_latency got=%0d exp=18", lat); end
    checks++; if (absr(f2r(r) - COS1) > TOL) begin failures++; $display("FAIL midreset_restart_value got=%h exp~3F0A5140", r); end
  endtask

  initial begin
    test_reset();
    test_cos_one();
    test_sin_cos();
    test_small();
    test_out_of_range();
    test_clk_en();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
